oled_layer_arbiter: RTL and testbench
=====================================

// Module: oled_layer_arbiter
// PURPOSE
//  Shares the single 96x64 RGB565 OLED pixel stream between N_LAYERS renderers (cursor, sprites, UI, background).
//  Per pixel: selects the highest-priority enabled layer whose colour is not the transparency key; registers the result.
//  Also owns the cursor position: accepts position/mask updates via valid/ready, clamps them, commits them at frame start (tear-free).
//  Sits between the layer renderers and the OLED driver, in the 6.25 MHz pixel clock domain.
// PARAMETERS
//  N_LAYERS     4         number of layers; index 0 = highest priority
//  KEY_COLOUR   16'h0000  transparency key; a layer pixel equal to it is ignored
//  BG_COLOUR    16'h0000  output when no layer wins
//  X_MIN/X_MAX  8/87      cursor_x clamp range, inclusive
//  Y_MIN/Y_MAX  14/63     cursor_y clamp range, inclusive
//  INIT_X/INIT_Y 48/62    cursor position after reset
// PORTS
//  CLOCK        in   1            6.25 MHz pixel clock
//  RESETN       in   1            synchronous reset, active-low
//  pixel_index  in   13           current OLED pixel, 0..6143, row-major, 96 per row
//  layer_pix    in   16*N_LAYERS  layer colours for pixel_index; layer i at [16i+15:16i]
//  req_x        in   12           requested cursor x (unclamped)
//  req_y        in   12           requested cursor y (unclamped)
//  req_mask     in   N_LAYERS     requested layer-enable mask
//  req_valid    in   1            update request
//  req_ready    out  1            update slot free
//  pixel_data   out  16           composited pixel to the OLED driver
//  cursor_x     out  12           committed cursor x (to renderers)
//  cursor_y     out  12           committed cursor y
//  layer_mask   out  N_LAYERS     committed layer enables
//  hit_layer    out  LW           winning layer index, LW=max(1,clog2(N_LAYERS))
//  hit_valid    out  1            1 = a layer won; 0 = BG_COLOUR shown
//  frame_start  out  1            one-cycle pulse on each frame wrap
//  frame_cnt    out  8            frame counter, wraps 255->0
// BEHAVIOUR
//  Reset (RESETN=0 at CLOCK edge): pixel_data=BG_COLOUR, hit_valid=0, hit_layer=0, cursor_x=INIT_X, cursor_y=INIT_Y,
//   layer_mask=all ones, req_ready=1, frame_start=0, frame_cnt=0, state=IDLE, shadow regs cleared, prev_index=0.
//  Compositing: latency 1 cycle. Cycle t inputs -> pixel_data/hit_layer/hit_valid at t+1.
//   Winner = lowest i with layer_mask[i]=1 and layer_pix[i]!=KEY_COLOUR; none -> BG_COLOUR, hit_valid=0, hit_layer=0.
//   Uses committed layer_mask as of cycle t; a commit in cycle t affects output from t+2.
//  Frame detect: prev_index registered each cycle; frame_start=1 for one cycle when pixel_index==0 && prev_index!=0.
//   Static pixel_index==0 gives one pulse only; frame_cnt increments on each pulse, modulo 256.
//  Update FSM, states IDLE, PENDING:
//   IDLE: req_ready=1. req_valid=1 -> shadow_x=clamp(req_x,X_MIN,X_MAX), shadow_y=clamp(req_y,Y_MIN,Y_MAX),
//    shadow_mask=req_mask; go PENDING (req_ready=0 next cycle).
//   PENDING: req_ready=0, req_valid ignored. On frame_start: cursor_x/y, layer_mask <= shadow; go IDLE.
//   Request accepted in the same cycle as frame_start commits at the NEXT frame_start, never the current one.
//   Clamp is unsigned 12-bit compare: values < MIN -> MIN, > MAX -> MAX.
//  Reset in PENDING discards the shadow; committed outputs take reset values.
//  A req_mask of all zeros is legal: output is BG_COLOUR everywhere.
// STRUCTURE
//  Package oled_pkg: OLED_W=96, OLED_H=64, OLED_PIXELS=6144, RGB565 colour constants, FSM state enum {IDLE,PENDING}.
//  Sub-module oled_frame_sync: prev_index register, frame_start pulse, frame_cnt. Instantiated once.
//  Priority mux: parameterised for-loop, scanned from high index to low so index 0 wins; registered output stage.
// TESTING
//  1 Reset: hold RESETN=0 two cycles -> cursor 48/62, mask 4'b1111, req_ready=1, pixel_data=0, frame_cnt=0.
//  2 Priority: mask 1111, layer_pix {L3=F800,L2=07E0,L1=0000,L0=0000} -> pixel_data=07E0, hit_layer=2, one cycle later.
//  3 Clamp+commit: req_x=200,req_y=3,req_valid pulse mid-frame -> req_ready=0; cursor unchanged until wrap 6143->0;
//    then cursor_x=87, cursor_y=14, req_ready=1 the cycle after frame_start.
//  4 Simultaneous: req_valid (x=50) in the frame_start cycle -> cursor_x stays old for the whole frame, becomes 50 at the next wrap.
//  5 Backpressure: second req_valid (x=30) while PENDING -> ignored; committed cursor_x = first request's clamped value.
//  6 Reset mid-PENDING, mask 0000 commit, frame_cnt 255->0 wrap -> reset values restored; output all BG_COLOUR; counter wraps.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared constants, colour values, FSM state type and clamp helper
// for the OLED layer arbiter.
package oled_pkg;

    localparam int OLED_W      = 96;
    localparam int OLED_H      = 64;
    localparam int OLED_PIXELS = OLED_W * OLED_H;
    localparam int IDX_W       = $clog2(OLED_PIXELS);

    localparam logic [15:0] RGB_BLACK = 16'h0000;
    localparam logic [15:0] RGB_RED   = 16'hF800;
    localparam logic [15:0] RGB_GREEN = 16'h07E0;
    localparam logic [15:0] RGB_BLUE  = 16'h001F;
    localparam logic [15:0] RGB_WHITE = 16'hFFFF;

    typedef enum logic {
        IDLE,
        PENDING
    } upd_state_t;

    function automatic logic [11:0] clamp12(
        input logic [11:0] v,
        input logic [11:0] lo,
        input logic [11:0] hi
    );
        if (v < lo)
            return lo;
        if (v > hi)
            return hi;
        return v;
    endfunction

endpackage

// File: rtl/oled_layer_arbiter_if.sv
// Cursor/mask update request channel with valid/ready handshake.
// The master drives the request, the arbiter answers with ready.
interface oled_layer_arbiter_if #(
    parameter int N_LAYERS = 4
) ();

    logic [11:0]         req_x;
    logic [11:0]         req_y;
    logic [N_LAYERS-1:0] req_mask;
    logic                req_valid;
    logic                req_ready;

    modport master (
        output req_x,
        output req_y,
        output req_mask,
        output req_valid,
        input  req_ready
    );

    modport slave (
        input  req_x,
        input  req_y,
        input  req_mask,
        input  req_valid,
        output req_ready
    );

endinterface

// File: rtl/oled_frame_sync.sv
// Detects the pixel_index wrap to 0 and emits a registered
// one-cycle frame_start pulse plus a free-running frame counter.
module oled_frame_sync
    import oled_pkg::*;
(
    input  logic             CLOCK,
    input  logic             RESETN,
    input  logic [IDX_W-1:0] pixel_index,
    output logic             frame_start,
    output logic [7:0]       frame_cnt
);

    logic [IDX_W-1:0] r_prev_index;
    logic             w_wrap;

    // Only the transition into 0 counts, so a stalled index pulses once.
    assign w_wrap = (pixel_index == '0) && (r_prev_index != '0);

    always_ff @(posedge CLOCK) begin
        if (!RESETN) begin
            r_prev_index <= '0;
            frame_start  <= 1'b0;
            frame_cnt    <= 8'd0;
        end else begin
            r_prev_index <= pixel_index;
            frame_start  <= w_wrap;
            if (w_wrap)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/oled_layer_arbiter.sv
// Per-pixel priority compositor for N_LAYERS renderers plus the
// tear-free cursor/mask update path committed at frame start.
module oled_layer_arbiter
    import oled_pkg::*;
#(
    parameter int          N_LAYERS   = 4,
    parameter logic [15:0] KEY_COLOUR = RGB_BLACK,
    parameter logic [15:0] BG_COLOUR  = RGB_BLACK,
    parameter logic [11:0] X_MIN      = 12'd8,
    parameter logic [11:0] X_MAX      = 12'd87,
    parameter logic [11:0] Y_MIN      = 12'd14,
    parameter logic [11:0] Y_MAX      = 12'd63,
    parameter logic [11:0] INIT_X     = 12'd48,
    parameter logic [11:0] INIT_Y     = 12'd62,
    localparam int         LW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
    input  logic                    CLOCK,
    input  logic                    RESETN,
    input  logic [IDX_W-1:0]        pixel_index,
    input  logic [16*N_LAYERS-1:0]  layer_pix,
    oled_layer_arbiter_if.slave     req,
    output logic [15:0]             pixel_data,
    output logic [11:0]             cursor_x,
    output logic [11:0]             cursor_y,
    output logic [N_LAYERS-1:0]     layer_mask,
    output logic [LW-1:0]           hit_layer,
    output logic                    hit_valid,
    output logic                    frame_start,
    output logic [7:0]              frame_cnt
);

    upd_state_t          r_state;
    upd_state_t          w_state_nxt;
    logic [11:0]         r_shadow_x;
    logic [11:0]         r_shadow_y;
    logic [N_LAYERS-1:0] r_shadow_mask;
    logic                w_accept;
    logic                w_commit;

    logic                w_hit;
    logic [LW-1:0]       w_hit_idx;
    logic [15:0]         w_colour;

    oled_frame_sync u_frame_sync (
        .CLOCK       (CLOCK),
        .RESETN      (RESETN),
        .pixel_index (pixel_index),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    // High-to-low scan: the last match written is the lowest index.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_colour  = BG_COLOUR;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (layer_mask[i] &&
                (layer_pix[16*i +: 16] != KEY_COLOUR)) begin
                w_hit     = 1'b1;
                w_hit_idx = LW'(i);
                w_colour  = layer_pix[16*i +: 16];
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESETN) begin
            pixel_data <= BG_COLOUR;
            hit_layer  <= '0;
            hit_valid  <= 1'b0;
        end else begin
            pixel_data <= w_colour;
            hit_layer  <= w_hit_idx;
            hit_valid  <= w_hit;
        end
    end

    assign w_accept = (r_state == IDLE) && req.req_valid;
    assign w_commit = (r_state == PENDING) && frame_start;

    always_ff @(posedge CLOCK) begin
        if (!RESETN)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (req.req_valid) w_state_nxt = PENDING;
            PENDING: if (frame_start)   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req.req_ready = (r_state == IDLE);
    end

    always_ff @(posedge CLOCK) begin
        if (!RESETN) begin
            r_shadow_x    <= '0;
            r_shadow_y    <= '0;
            r_shadow_mask <= '0;
        end else if (w_accept) begin
            r_shadow_x    <= clamp12(req.req_x, X_MIN, X_MAX);
            r_shadow_y    <= clamp12(req.req_y, Y_MIN, Y_MAX);
            r_shadow_mask <= req.req_mask;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESETN) begin
            cursor_x   <= INIT_X;
            cursor_y   <= INIT_Y;
            layer_mask <= '1;
        end else if (w_commit) begin
            cursor_x   <= r_shadow_x;
            cursor_y   <= r_shadow_y;
            layer_mask <= r_shadow_mask;
        end
    end

endmodule

// File: tb/tb_oled_layer_arbiter.sv
// Directed bench for oled_layer_arbiter: reset, priority, clamp,
// commit timing, backpressure, reset-in-pending and counter wrap.
module tb_oled_layer_arbiter;

    logic        CLOCK;
    logic        RESETN;
    logic [12:0] pixel_index;
    logic [63:0] layer_pix;
    logic [15:0] pixel_data;
    logic [11:0] cursor_x;
    logic [11:0] cursor_y;
    logic [3:0]  layer_mask;
    logic [1:0]  hit_layer;
    logic        hit_valid;
    logic        frame_start;
    logic [7:0]  frame_cnt;

    int total = 0;
    int bad   = 0;

    oled_layer_arbiter_if #(.N_LAYERS(4)) u_if ();

    oled_layer_arbiter u_dut (
        .CLOCK       (CLOCK),
        .RESETN      (RESETN),
        .pixel_index (pixel_index),
        .layer_pix   (layer_pix),
        .req         (u_if),
        .pixel_data  (pixel_data),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .layer_mask  (layer_mask),
        .hit_layer   (hit_layer),
        .hit_valid   (hit_valid),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_frame();
        pixel_index = 13'd1;
        tick();
        pixel_index = 13'd0;
        tick();
    endtask

    initial begin
        RESETN         = 1'b0;
        pixel_index    = 13'd0;
        layer_pix      = '0;
        u_if.req_x     = '0;
        u_if.req_y     = '0;
        u_if.req_mask  = '0;
        u_if.req_valid = 1'b0;

        tick();
        tick();
        chk("rst_cx", 32'(cursor_x), 32'd48);
        chk("rst_cy", 32'(cursor_y), 32'd62);
        chk("rst_mask", 32'(layer_mask), 32'hF);
        chk("rst_ready", 32'(u_if.req_ready), 32'd1);
        chk("rst_pix", 32'(pixel_data), 32'h0);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
        chk("rst_hitv", 32'(hit_valid), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        RESETN = 1'b1;

        pixel_index = 13'd5;
        layer_pix   = {16'hF800, 16'h07E0, 16'h0000, 16'h0000};
        tick();
        chk("prio_pix", 32'(pixel_data), 32'h07E0);
        chk("prio_hit", 32'(hit_layer), 32'd2);
        chk("prio_hitv", 32'(hit_valid), 32'd1);
        layer_pix = {16'hF800, 16'h07E0, 16'h0000, 16'h001F};
        tick();
        chk("prio0_pix", 32'(pixel_data), 32'h001F);
        chk("prio0_hit", 32'(hit_layer), 32'd0);
        layer_pix = '0;
        tick();
        chk("bg_pix", 32'(pixel_data), 32'h0);
        chk("bg_hitv", 32'(hit_valid), 32'd0);
        chk("bg_hit", 32'(hit_layer), 32'd0);
        chk("no_fs", 32'(frame_start), 32'd0);

        pixel_index    = 13'd100;
        u_if.req_x     = 12'd200;
        u_if.req_y     = 12'd3;
        u_if.req_mask  = 4'hF;
        u_if.req_valid = 1'b1;
        tick();
        u_if.req_valid = 1'b0;
        chk("clamp_ready0", 32'(u_if.req_ready), 32'd0);
        chk("clamp_cx_old", 32'(cursor_x), 32'd48);
        pixel_index = 13'd6143;
        tick();
        chk("clamp_cx_6143", 32'(cursor_x), 32'd48);
        pixel_index = 13'd0;
        tick();
        chk("wrap_fs", 32'(frame_start), 32'd1);
        chk("wrap_cx_fs", 32'(cursor_x), 32'd48);
        chk("wrap_fcnt", 32'(frame_cnt), 32'd1);
        tick();
        chk("fs_onepulse", 32'(frame_start), 32'd0);
        chk("commit_cx", 32'(cursor_x), 32'd87);
        chk("commit_cy", 32'(cursor_y), 32'd14);
        chk("commit_ready", 32'(u_if.req_ready), 32'd1);
        tick();
        chk("static0_fs", 32'(frame_start), 32'd0);

        new_frame();
        chk("sim_fs", 32'(frame_start), 32'd1);
        u_if.req_x     = 12'd50;
        u_if.req_y     = 12'd20;
        u_if.req_mask  = 4'hF;
        u_if.req_valid = 1'b1;
        pixel_index    = 13'd1;
        tick();
        u_if.req_valid = 1'b0;
        chk("sim_ready0", 32'(u_if.req_ready), 32'd0);
        chk("sim_cx_old", 32'(cursor_x), 32'd87);
        pixel_index = 13'd2;
        tick();
        tick();
        chk("sim_cx_mid", 32'(cursor_x), 32'd87);
        pixel_index = 13'd0;
        tick();
        chk("sim_fs2", 32'(frame_start), 32'd1);
        chk("sim_cx_fs2", 32'(cursor_x), 32'd87);
        tick();
        chk("sim_cx_new", 32'(cursor_x), 32'd50);
        chk("sim_cy_new", 32'(cursor_y), 32'd20);
        chk("sim_fcnt", 32'(frame_cnt), 32'd3);

        pixel_index    = 13'd1;
        u_if.req_x     = 12'd5;
        u_if.req_y     = 12'd100;
        u_if.req_mask  = 4'b0101;
        u_if.req_valid = 1'b1;
        tick();
        u_if.req_x = 12'd30;
        u_if.req_y = 12'd30;
        u_if.req_mask = 4'hF;
        tick();
        tick();
        u_if.req_valid = 1'b0;
        pixel_index = 13'd0;
        tick();
        tick();
        chk("bp_cx", 32'(cursor_x), 32'd8);
        chk("bp_cy", 32'(cursor_y), 32'd63);
        chk("bp_mask", 32'(layer_mask), 32'b0101);
        chk("bp_ready", 32'(u_if.req_ready), 32'd1);
        layer_pix = {16'hF800, 16'h07E0, 16'h001F, 16'h0000};
        tick();
        chk("bp_pix", 32'(pixel_data), 32'h07E0);
        chk("bp_hit", 32'(hit_layer), 32'd2);

        pixel_index    = 13'd1;
        u_if.req_x     = 12'd60;
        u_if.req_y     = 12'd30;
        u_if.req_mask  = 4'b0000;
        u_if.req_valid = 1'b1;
        tick();
        u_if.req_valid = 1'b0;
        chk("pend_ready0", 32'(u_if.req_ready), 32'd0);
        RESETN = 1'b0;
        tick();
        chk("rst2_cx", 32'(cursor_x), 32'd48);
        chk("rst2_cy", 32'(cursor_y), 32'd62);
        chk("rst2_mask", 32'(layer_mask), 32'hF);
        chk("rst2_ready", 32'(u_if.req_ready), 32'd1);
        chk("rst2_fcnt", 32'(frame_cnt), 32'd0);
        chk("rst2_pix", 32'(pixel_data), 32'h0);
        RESETN = 1'b1;
        tick();
        pixel_index = 13'd0;
        tick();
        chk("rst2_fs", 32'(frame_start), 32'd1);
        tick();
        chk("discard_cx", 32'(cursor_x), 32'd48);
        chk("discard_mask", 32'(layer_mask), 32'hF);

        pixel_index    = 13'd1;
        u_if.req_x     = 12'd48;
        u_if.req_y     = 12'd62;
        u_if.req_mask  = 4'b0000;
        u_if.req_valid = 1'b1;
        tick();
        u_if.req_valid = 1'b0;
        pixel_index = 13'd0;
        tick();
        tick();
        chk("zmask", 32'(layer_mask), 32'h0);
        layer_pix = {16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
        tick();
        chk("zmask_pix", 32'(pixel_data), 32'h0);
        chk("zmask_hitv", 32'(hit_valid), 32'd0);
        chk("zmask_hit", 32'(hit_layer), 32'd0);
        chk("fcnt_2", 32'(frame_cnt), 32'd2);

        for (int k = 0; k < 253; k++)
            new_frame();
        chk("fcnt_255", 32'(frame_cnt), 32'd255);
        new_frame();
        chk("fcnt_wrap", 32'(frame_cnt), 32'd0);
        chk("wrap_pulse", 32'(frame_start), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
